// File: rtl/sdr_disc_pkg.sv
// Shared constants and types for the discovery reply builder.
// Payload byte offsets, status codes and the one-hot FSM encoding.
package sdr_disc_pkg;

  localparam logic [15:0] OffSeq    = 16'd0;
  localparam logic [15:0] OffStatus = 16'd4;
  localparam logic [15:0] OffMac    = 16'd5;
  localparam logic [15:0] OffBoard  = 16'd11;
  localparam logic [15:0] OffProto  = 16'd12;
  localparam logic [15:0] OffFw     = 16'd13;
  localparam logic [15:0] OffNrx    = 16'd20;

  localparam logic [7:0] StatusIdle    = 8'h02;
  localparam logic [7:0] StatusRunning = 8'h03;

  typedef enum logic [4:0] {
    StIdle    = 5'b00001,
    StAck     = 5'b00010,
    StReq     = 5'b00100,
    StSend    = 5'b01000,
    StRelease = 5'b10000
  } state_e;

endpackage

// File: rtl/sdr_discovery_reply_if.sv
// Bundles the sdr_receive handshake, identity/status inputs and the UDP transmit bus.
// master = reply builder, slave = surrounding environment.
interface sdr_discovery_reply_if;
  logic        discovery_reply;
  logic        discovery_ACK;
  logic        sending_sync;
  logic [31:0] sequence_number;
  logic [47:0] local_mac;
  logic        radio_running;
  logic        udp_tx_request;
  logic        udp_tx_enable;
  logic [7:0]  udp_tx_data;
  logic [15:0] udp_tx_length;

  modport master (
    input  discovery_reply, sequence_number, local_mac, radio_running, udp_tx_enable,
    output discovery_ACK, sending_sync, udp_tx_request, udp_tx_data, udp_tx_length
  );

  modport slave (
    output discovery_reply, sequence_number, local_mac, radio_running, udp_tx_enable,
    input  discovery_ACK, sending_sync, udp_tx_request, udp_tx_data, udp_tx_length
  );
endinterface

// File: rtl/sdr_disc_byte_mux.sv
// Combinational payload byte selection from the snapshot fields by byte index.
// The parent registers the result.
module sdr_disc_byte_mux
  import sdr_disc_pkg::*;
#(
  parameter logic [7:0] BOARD_ID         = 8'h0A,
  parameter logic [7:0] PROTOCOL_VERSION = 8'd38,
  parameter logic [7:0] FW_VERSION       = 8'd10,
  parameter logic [7:0] NUM_RX           = 8'd2
) (
  input  logic [15:0] idx_i,
  input  logic [31:0] seq_i,
  input  logic [47:0] mac_i,
  input  logic [7:0]  status_i,
  output logic [7:0]  byte_o
);

  logic [15:0] seq_off;
  logic [15:0] mac_off;
  logic [31:0] seq_sh;
  logic [47:0] mac_sh;

  always_comb begin
    seq_off = idx_i - OffSeq;
    mac_off = idx_i - OffMac;
    // MSB-first fields: shift the wanted byte up into the top lane
    seq_sh  = seq_i << {seq_off[1:0], 3'b000};
    mac_sh  = mac_i << {mac_off[2:0], 3'b000};
    byte_o  = 8'h00;
    if (idx_i < OffStatus)       byte_o = seq_sh[31:24];
    else if (idx_i == OffStatus) byte_o = status_i;
    else if (idx_i < OffBoard)   byte_o = mac_sh[47:40];
    else if (idx_i == OffBoard)  byte_o = BOARD_ID;
    else if (idx_i == OffProto)  byte_o = PROTOCOL_VERSION;
    else if (idx_i == OffFw)     byte_o = FW_VERSION;
    else if (idx_i == OffNrx)    byte_o = NUM_RX;
  end

endmodule

// File: rtl/sdr_discovery_reply.sv
// Protocol-2 discovery reply builder: four-phase ACK to sdr_receive, snapshot, byte streaming.
// Optional macro SDR_DISC_RUNNING_STATUS_EN reports radio_running in the status byte.
module sdr_discovery_reply
  import sdr_disc_pkg::*;
#(
  parameter logic [7:0]  BOARD_ID         = 8'h0A,
  parameter logic [7:0]  PROTOCOL_VERSION = 8'd38,
  parameter logic [7:0]  FW_VERSION       = 8'd10,
  parameter logic [7:0]  NUM_RX           = 8'd2,
  parameter logic [15:0] REPLY_LEN        = 16'd60,
  parameter logic [15:0] GRANT_TIMEOUT    = 16'd50000
) (
  input  logic                  tx_clock,
  input  logic                  reset,
  sdr_discovery_reply_if.master bus
);

  state_e      state_q, state_d;
  logic        sync1_q, req_s_q;
  logic        ack_q, ack_d;
  logic        sync_q, sync_d;
  logic        req_q, req_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] seq_q, seq_d;
  logic [47:0] mac_q, mac_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  mux_byte;
  logic [7:0]  status_now;

`ifdef SDR_DISC_RUNNING_STATUS_EN
  assign status_now = bus.radio_running ? StatusRunning : StatusIdle;
`else
  assign status_now = StatusIdle;
`endif

  // Mux is driven by the next index so data_q always matches idx_q.
  sdr_disc_byte_mux #(
    .BOARD_ID         (BOARD_ID),
    .PROTOCOL_VERSION (PROTOCOL_VERSION),
    .FW_VERSION       (FW_VERSION),
    .NUM_RX           (NUM_RX)
  ) u_byte_mux (
    .idx_i    (idx_d),
    .seq_i    (seq_q),
    .mac_i    (mac_q),
    .status_i (status_q),
    .byte_o   (mux_byte)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    sync_d   = sync_q;
    req_d    = req_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    mac_d    = mac_q;
    status_d = status_q;
    unique case (state_q)
      StIdle: begin
        if (req_s_q && !ack_q) begin
          ack_d    = 1'b1;
          sync_d   = 1'b1;
          seq_d    = bus.sequence_number;
          mac_d    = bus.local_mac;
          status_d = status_now;
          state_d  = StAck;
        end
      end
      StAck: begin
        req_d   = 1'b1;
        idx_d   = 16'd0;
        cnt_d   = 16'd0;
        state_d = StReq;
      end
      StReq: begin
        if (bus.udp_tx_enable) begin
          idx_d   = 16'd1;
          state_d = StSend;
        end else if (cnt_q == GRANT_TIMEOUT - 16'd1) begin
          req_d   = 1'b0;
          sync_d  = 1'b0;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StSend: begin
        if (bus.udp_tx_enable) begin
          if (idx_q == REPLY_LEN - 16'd1) begin
            req_d   = 1'b0;
            sync_d  = 1'b0;
            idx_d   = 16'd0;
            state_d = StRelease;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      StRelease: begin
        if (!req_s_q) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    data_d = req_d ? mux_byte : 8'h00;
  end

  always_ff @(posedge tx_clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      sync1_q  <= 1'b0;
      req_s_q  <= 1'b0;
      ack_q    <= 1'b0;
      sync_q   <= 1'b0;
      req_q    <= 1'b0;
      idx_q    <= 16'd0;
      cnt_q    <= 16'd0;
      seq_q    <= 32'd0;
      mac_q    <= 48'd0;
      status_q <= 8'd0;
      data_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= bus.discovery_reply;
      req_s_q  <= sync1_q;
      ack_q    <= ack_d;
      sync_q   <= sync_d;
      req_q    <= req_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      mac_q    <= mac_d;
      status_q <= status_d;
      data_q   <= data_d;
    end
  end

  assign bus.discovery_ACK  = ack_q;
  assign bus.sending_sync   = sync_q;
  assign bus.udp_tx_request = req_q;
  assign bus.udp_tx_data    = data_q;
  assign bus.udp_tx_length  = req_q ? REPLY_LEN : 16'd0;

endmodule

// File: tb/tb_sdr_discovery_reply.sv
// Self-checking bench for sdr_discovery_reply against a payload model built from the packet layout.
module tb_sdr_discovery_reply;

  logic tx_clock = 1'b0;
  logic reset;

  sdr_discovery_reply_if bus();

  sdr_discovery_reply dut (
    .tx_clock (tx_clock),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 tx_clock = ~tx_clock;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_seq;
  logic [47:0] m_mac;
  logic        m_run;

  // Expected payload byte n, straight from the packet layout.
  function automatic logic [7:0] model_byte(input int n);
    logic [7:0] st;
`ifdef SDR_DISC_RUNNING_STATUS_EN
    st = m_run ? 8'h03 : 8'h02;
`else
    st = 8'h02;
`endif
    if (n < 4)        return 8'(m_seq >> (8 * (3 - n)));
    else if (n == 4)  return st;
    else if (n < 11)  return 8'(m_mac >> (8 * (10 - n)));
    else if (n == 11) return 8'h0A;
    else if (n == 12) return 8'd38;
    else if (n == 13) return 8'd10;
    else if (n == 20) return 8'd2;
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clock);
    #1;
  endtask

  task automatic start_req(input string tag);
    bus.sequence_number = m_seq;
    bus.local_mac       = m_mac;
    bus.radio_running   = m_run;
    bus.discovery_reply = 1'b1;
    tick();
    tick();
    check({tag, "_ack_early"}, 64'(bus.discovery_ACK), 64'd0);
    tick();
    check({tag, "_ack_3clk"}, 64'(bus.discovery_ACK), 64'd1);
    check({tag, "_sync_3clk"}, 64'(bus.sending_sync), 64'd1);
    check({tag, "_req_early"}, 64'(bus.udp_tx_request), 64'd0);
    tick();
    check({tag, "_req_4clk"}, 64'(bus.udp_tx_request), 64'd1);
    check({tag, "_len"}, 64'(bus.udp_tx_length), 64'd60);
  endtask

  // mode 0: continuous grant, 1: 1,0,0 stall pattern, 2: random grant + input scramble,
  // 3: continuous grant with discovery_reply pulsed low/high mid-packet.
  task automatic run_packet(input string tag, input int mode, input int abort_at,
                            output int nb);
    int   cyc;
    logic en;
    nb  = 0;
    cyc = 0;
    while (bus.udp_tx_request && cyc < 2000) begin
      if (nb == abort_at) break;
      check($sformatf("%s_byte%0d", tag, nb), 64'(bus.udp_tx_data), 64'(model_byte(nb)));
      case (mode)
        0:       en = 1'b1;
        1:       en = (cyc % 3 == 0);
        2:       en = 1'($urandom_range(0, 1));
        default: en = 1'b1;
      endcase
      if (mode == 2 && cyc == 2) begin
        bus.sequence_number = $urandom;
        bus.local_mac       = 48'({$urandom, $urandom});
        bus.radio_running   = ~m_run;
      end
      if (mode == 3 && cyc == 10) bus.discovery_reply = 1'b0;
      if (mode == 3 && cyc == 15) bus.discovery_reply = 1'b1;
      bus.udp_tx_enable = en;
      tick();
      if (en) nb++;
      cyc++;
    end
    bus.udp_tx_enable = 1'b0;
  endtask

  task automatic post_checks(input string tag, input int nb);
    check({tag, "_count"}, 64'(nb), 64'd60);
    check({tag, "_req_drop"}, 64'(bus.udp_tx_request), 64'd0);
    check({tag, "_sync_drop"}, 64'(bus.sending_sync), 64'd0);
    check({tag, "_ack_held"}, 64'(bus.discovery_ACK), 64'd1);
    check({tag, "_len_zero"}, 64'(bus.udp_tx_length), 64'd0);
  endtask

  task automatic finish_handshake(input string tag);
    int n;
    n = 0;
    bus.discovery_reply = 1'b0;
    while (bus.discovery_ACK && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_ack_release_clks"}, 64'(n), 64'd3);
    check({tag, "_ack_low"}, 64'(bus.discovery_ACK), 64'd0);
  endtask

  initial begin
    int nb;
    int n;
    int hits;

    reset               = 1'b1;
    bus.discovery_reply = 1'b0;
    bus.sequence_number = 32'd0;
    bus.local_mac       = 48'd0;
    bus.radio_running   = 1'b0;
    bus.udp_tx_enable   = 1'b0;
    tick();
    tick();
    check("rst_ack", 64'(bus.discovery_ACK), 64'd0);
    check("rst_sync", 64'(bus.sending_sync), 64'd0);
    check("rst_req", 64'(bus.udp_tx_request), 64'd0);
    check("rst_data", 64'(bus.udp_tx_data), 64'd0);
    check("rst_len", 64'(bus.udp_tx_length), 64'd0);
    reset = 1'b0;
    tick();

    // Basic reply with the documented example fields
    m_seq = 32'h01020304;
    m_mac = 48'h001CC0A213DD;
    m_run = 1'b0;
    start_req("basic");
    run_packet("basic", 0, -1, nb);
    post_checks("basic", nb);
    finish_handshake("basic");
    tick();

    // Stalled grant, same payload
    start_req("stall");
    run_packet("stall", 1, -1, nb);
    post_checks("stall", nb);
    finish_handshake("stall");
    tick();

    // Radio running status
    m_run = 1'b1;
    start_req("status");
    run_packet("status", 0, -1, nb);
    post_checks("status", nb);
    finish_handshake("status");
    tick();

    // Randomized fields and grant; inputs change after snapshot
    for (int i = 0; i < 3; i++) begin
      m_seq = $urandom;
      m_mac = 48'({$urandom, $urandom});
      m_run = 1'($urandom_range(0, 1));
      start_req($sformatf("rand%0d", i));
      run_packet($sformatf("rand%0d", i), 2, -1, nb);
      post_checks($sformatf("rand%0d", i), nb);
      finish_handshake($sformatf("rand%0d", i));
      tick();
    end

    // Second request during SEND is ignored until the handshake completes
    m_seq = $urandom;
    m_run = 1'b0;
    start_req("repeat");
    run_packet("repeat", 3, -1, nb);
    post_checks("repeat", nb);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.udp_tx_request || !bus.discovery_ACK) hits++;
    end
    check("repeat_no_extra", 64'(hits), 64'd0);
    finish_handshake("repeat");
    tick();
    m_seq = $urandom;
    start_req("repeat2");
    run_packet("repeat2", 0, -1, nb);
    post_checks("repeat2", nb);
    finish_handshake("repeat2");
    tick();

    // Reset at byte 30
    m_seq = $urandom;
    start_req("rstmid");
    run_packet("rstmid", 0, 30, nb);
    check("rstmid_reached", 64'(nb), 64'd30);
    reset = 1'b1;
    #1;
    check("rstmid_ack", 64'(bus.discovery_ACK), 64'd0);
    check("rstmid_sync", 64'(bus.sending_sync), 64'd0);
    check("rstmid_req", 64'(bus.udp_tx_request), 64'd0);
    check("rstmid_data", 64'(bus.udp_tx_data), 64'd0);
    check("rstmid_len", 64'(bus.udp_tx_length), 64'd0);
    bus.discovery_reply = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.udp_tx_request || bus.sending_sync || bus.discovery_ACK) hits++;
    end
    check("rstmid_no_resume", 64'(hits), 64'd0);
    start_req("postrst");
    run_packet("postrst", 0, -1, nb);
    post_checks("postrst", nb);
    finish_handshake("postrst");
    tick();

    // Grant timeout
    start_req("tmo");
    n = 0;
    while (bus.udp_tx_request && n < 50010) begin
      tick();
      n++;
    end
    check("tmo_clks", 64'(n), 64'd50000);
    check("tmo_sync", 64'(bus.sending_sync), 64'd0);
    check("tmo_ack_held", 64'(bus.discovery_ACK), 64'd1);
    finish_handshake("tmo");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
